load_store_buffer: RTL and testbench
====================================

LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

Interface
REQ-001 Parameters SHALL be: DEPTH, 8, queue entries (power of two); TAG_W, 4, ROB tag width.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- clear  in  1  ROB misprediction flush
- push_i  in  1  enqueue op from LoadStoreRS
- op_i  in  4  {is_store, funct3}
- addr_i  in  32  effective address
- data_i  in  32  store data
- tag_i  in  TAG_W  ROB tag
- full_o  out  1  registered almost-full
- commit_en_i  in  1  ROB commit credit pulse
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write
- mem_size_o  out  2  00 byte / 01 half / 10 word
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  store data
- mem_done_i  in  1  transaction complete
- mem_rdata_i  in  32  load data, LSB-aligned
- cdb_LS_en_o  out  1  load result valid
- cdb_LS_tag_o  out  TAG_W  load tag
- cdb_LS_data_o  out  32  extended load data

Function
REQ-003 The queue SHALL be a circular FIFO with head, tail and count registers; pointers SHALL wrap from DEPTH-1 to 0.
REQ-004 A credit counter (log2(DEPTH)+1 bits) SHALL increment on each commit_en_i; the oldest `credit` entries are committed.
REQ-005 A commit_en_i arriving while credit == count SHALL be ignored.
REQ-006 full_o SHALL be registered high when next count >= DEPTH-1; push_i while count == DEPTH SHALL be ignored.
REQ-007 The FSM SHALL have two states, IDLE and BUSY.
REQ-008 IDLE -> BUSY when count > 0 and credit > 0; in that cycle mem_req_o rises with head entry fields, and size = funct3[1:0].
REQ-009 In BUSY, mem_req_o and the mem_* fields SHALL stay stable until mem_done_i is sampled high.
REQ-010 On mem_done_i, the FSM SHALL return to IDLE, pop head, and decrement count and credit; mem_req_o SHALL be low the next cycle.
REQ-011 Issue latency SHALL be one cycle from credit to mem_req_o; back-to-back ops SHALL have at least one IDLE cycle.
REQ-012 On a load done, cdb_LS_en_o SHALL pulse one cycle later with tag and data.
REQ-013 Load data extension: funct3 000 sign-extends a byte; 001 sign-extends a half; 010 passes the word; 100 zero-extends a byte; 101 zero-extends a half.
REQ-014 Stores SHALL produce no CDB output.
REQ-015 Simultaneous push, pop and credit SHALL each apply in the same cycle; count = count + push - pop.
REQ-016 On clear, only uncommitted entries SHALL be dropped: tail <= head + credit, count <= credit, credit retained.
REQ-017 An in-flight transaction SHALL complete after clear; a load in flight during clear SHALL suppress its CDB pulse.
REQ-018 If clear and commit_en_i occur in the same cycle, the credit SHALL be applied before truncation.
REQ-019 A push coinciding with clear SHALL be discarded.
REQ-020 While rdy is low, no register SHALL change and mem_req_o SHALL hold its value.

Reset
REQ-021 On rst: head, tail, count and credit SHALL be 0 and the FSM SHALL be IDLE.
REQ-022 On rst: full_o, mem_req_o, mem_we_o and cdb_LS_en_o SHALL be 0; all data outputs SHALL be 0.
REQ-023 Reset mid-transaction SHALL abandon the transaction, with mem_req_o low the following cycle.

Configuration
REQ-024 With LSB_STALL_CNT_EN defined, output stall_cnt_o (32 bits) SHALL count cycles in BUSY with mem_done_i low.
REQ-025 stall_cnt_o SHALL reset to 0 and wrap modulo 2^32.
REQ-026 Without LSB_STALL_CNT_EN, the port and the counter SHALL be absent.

Verification
REQ-027 Push LB addr 0x100, credit, mem_rdata_i 0x00000080 -> cdb_LS_data_o 0xFFFFFF80 with the pushed tag; LBU with the same data -> 0x00000080.
REQ-028 Push SW 0x200/0xDEADBEEF without credit for 20 cycles -> mem_req_o stays 0; credit -> mem_req_o=1, mem_we_o=1, size 10, wdata 0xDEADBEEF.
REQ-029 Push 8 entries -> full_o=1 after 7, 9th push ignored; commit all -> 8 ordered transactions, count returns to 0, head wraps to 0.
REQ-030 Push 4, credit 1, clear -> only the first op issues, count=0 after done, no CDB for dropped tags.
REQ-031 Load in BUSY, clear, then mem_done_i -> no cdb_LS_en_o pulse, FSM IDLE.
REQ-032 rst asserted while BUSY -> next cycle all outputs 0, count=0; with LSB_STALL_CNT_EN, 5 stall cycles -> stall_cnt_o=5 before reset, 0 after.

Source files
------------

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store queue that issues committed ops to memory and returns load results on the CDB.
// Define LSB_STALL_CNT_EN to add stall_cnt_o, counting BUSY cycles spent waiting on mem_done_i.
module load_store_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             push_i,
  input  logic [3:0]       op_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             full_o,
  input  logic             commit_en_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [1:0]       mem_size_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_done_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             cdb_LS_en_o,
  output logic [TAG_W-1:0] cdb_LS_tag_o,
  output logic [31:0]      cdb_LS_data_o
`ifdef LSB_STALL_CNT_EN
  , output logic [31:0]    stall_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [3:0] op_q [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [AW-1:0] head, tail, head_n;
  logic [AW:0] count, credit, count_n, credit_n;
  logic push_acc, commit_acc, pop, kill;
  logic [2:0] f3;
  logic [TAG_W-1:0] cur_tag;
  logic [31:0] ld_val;
  assign pop = state == BUSY && mem_done_i;
  assign push_acc = push_i && count != (AW+1)'(DEPTH) && !clear;
  assign commit_acc = commit_en_i && credit != count;
  assign credit_n = credit + (AW+1)'(commit_acc) - (AW+1)'(pop);
  assign count_n = clear ? credit_n : count + (AW+1)'(push_acc) - (AW+1)'(pop);
  assign head_n = head + AW'(pop);
  assign ld_val = f3[1:0] == 2'b00 ? {{24{~f3[2] & mem_rdata_i[7]}}, mem_rdata_i[7:0]} :
                  f3[1:0] == 2'b01 ? {{16{~f3[2] & mem_rdata_i[15]}}, mem_rdata_i[15:0]} : mem_rdata_i;
  always_ff @(posedge clk)
    if (rdy && push_acc) begin
      op_q[tail] <= op_i;
      addr_q[tail] <= addr_i;
      data_q[tail] <= data_i;
      tag_q[tail] <= tag_i;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      credit <= '0;
      full_o <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_size_o <= '0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      cdb_LS_en_o <= 1'b0;
      cdb_LS_tag_o <= '0;
      cdb_LS_data_o <= '0;
      kill <= 1'b0;
      f3 <= '0;
      cur_tag <= '0;
    end else if (rdy) begin
      head <= head_n;
      credit <= credit_n;
      count <= count_n;
      // a flush keeps exactly the committed prefix starting at the (post-pop) head
      tail <= clear ? head_n + credit_n[AW-1:0] : tail + AW'(push_acc);
      full_o <= count_n >= (AW+1)'(DEPTH-1);
      cdb_LS_en_o <= 1'b0;
      if (state == IDLE) begin
        if (count != '0 && credit != '0) begin
          state <= BUSY;
          mem_req_o <= 1'b1;
          mem_we_o <= op_q[head][3];
          mem_size_o <= op_q[head][1:0];
          mem_addr_o <= addr_q[head];
          mem_wdata_o <= data_q[head];
          f3 <= op_q[head][2:0];
          cur_tag <= tag_q[head];
          kill <= 1'b0;
        end
      end else if (mem_done_i) begin
        state <= IDLE;
        mem_req_o <= 1'b0;
        if (!mem_we_o && !kill && !clear) begin
          cdb_LS_en_o <= 1'b1;
          cdb_LS_tag_o <= cur_tag;
          cdb_LS_data_o <= ld_val;
        end
      end else
        kill <= kill | clear;
    end
`ifdef LSB_STALL_CNT_EN
  always_ff @(posedge clk)
    if (rst)
      stall_cnt_o <= '0;
    else if (rdy && state == BUSY && !mem_done_i)
      stall_cnt_o <= stall_cnt_o + 32'd1;
`endif
endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_load_store_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0, push_i = 1'b0, commit_en_i = 1'b0, mem_done_i = 1'b0;
  logic [3:0] op_i = '0;
  logic [31:0] addr_i = '0, data_i = '0, mem_rdata_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic full_o, mem_req_o, mem_we_o, cdb_LS_en_o;
  logic [1:0] mem_size_o;
  logic [31:0] mem_addr_o, mem_wdata_o, cdb_LS_data_o;
  logic [TAG_W-1:0] cdb_LS_tag_o;
`ifdef LSB_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif
  load_store_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .push_i(push_i), .op_i(op_i),
    .addr_i(addr_i), .data_i(data_i), .tag_i(tag_i), .full_o(full_o), .commit_en_i(commit_en_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i),
    .cdb_LS_en_o(cdb_LS_en_o), .cdb_LS_tag_o(cdb_LS_tag_o), .cdb_LS_data_o(cdb_LS_data_o)
`ifdef LSB_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] op; logic [31:0] addr, data; logic [TAG_W-1:0] tag;} ent_t;
  ent_t q[$];
  ent_t m_cur;
  int m_credit, n_tests, n_fail;
  bit m_busy, m_kill, m_full, e_cdb;
  logic [TAG_W-1:0] e_tag;
  logic [31:0] e_data, m_stall;
  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] r);
    case (f)
      3'b000: return 32'($signed(r[7:0]));
      3'b001: return 32'($signed(r[15:0]));
      3'b100: return {24'd0, r[7:0]};
      3'b101: return {16'd0, r[15:0]};
      default: return r;
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic model_step();
    int n;
    bit pop, iss, ca;
    if (rst) begin
      q.delete();
      m_credit = 0; m_busy = 0; m_kill = 0; m_full = 0; e_cdb = 0; m_stall = 0;
      return;
    end
    if (!rdy) return;
    n = q.size();
    pop = m_busy && mem_done_i;
    iss = !m_busy && n > 0 && m_credit > 0;
    ca = commit_en_i && m_credit != n;
    e_cdb = 0;
    if (pop && !m_cur.op[3] && !m_kill && !clear) begin
      e_cdb = 1; e_tag = m_cur.tag; e_data = ext(m_cur.op[2:0], mem_rdata_i);
    end
    if (m_busy && !mem_done_i) begin
      m_stall++;
      if (clear) m_kill = 1;
    end
    if (iss) begin m_cur = q[0]; m_kill = 0; m_busy = 1; end
    if (pop) begin void'(q.pop_front()); m_busy = 0; end
    m_credit = m_credit + int'(ca) - int'(pop);
    if (push_i && n != DEPTH && !clear) q.push_back('{op_i, addr_i, data_i, tag_i});
    if (clear) while (q.size() > m_credit) void'(q.pop_back());
    m_full = q.size() >= DEPTH - 1;
  endtask
  task automatic compare_all();
    chk("mem_req", mem_req_o, m_busy);
    if (m_busy) begin
      chk("mem_we", mem_we_o, m_cur.op[3]);
      chk("mem_size", mem_size_o, m_cur.op[1:0]);
      chk("mem_addr", mem_addr_o, m_cur.addr);
      chk("mem_wdata", mem_wdata_o, m_cur.data);
    end
    chk("full", full_o, m_full);
    chk("cdb_en", cdb_LS_en_o, e_cdb);
    if (e_cdb) begin
      chk("cdb_tag", cdb_LS_tag_o, e_tag);
      chk("cdb_data", cdb_LS_data_o, e_data);
    end
`ifdef LSB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, m_stall);
`endif
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    rst = 0; rdy = 1; push_i = 0; commit_en_i = 0; clear = 0; mem_done_i = 0;
  endtask
  task automatic push(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d, input logic [TAG_W-1:0] t);
    push_i = 1; op_i = o; addr_i = a; data_i = d; tag_i = t;
    tick();
  endtask
  task automatic wait_busy(input string n);
    int k = 0;
    while (!m_busy && k < 10) begin tick(); k++; end
    chk(n, mem_req_o, 1);
  endtask
  function automatic logic [3:0] rand_op();
    logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    return $urandom_range(0, 1) ? {2'b10, 2'($urandom_range(0, 2))} : {1'b0, lf[$urandom_range(0, 4)]};
  endfunction
  initial begin
    logic [TAG_W-1:0] got[$];
    bit seen;
    int ncdb;
    rst = 1; tick();
    rst = 1; tick();
    chk("rst_req", mem_req_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_cdb", cdb_LS_en_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    // LB then LBU of the same byte
    push(4'b0000, 32'h100, 32'h0, 4'd5);
    commit_en_i = 1; tick();
    wait_busy("lb_issue");
    chk("lb_addr", mem_addr_o, 32'h100);
    chk("lb_size", mem_size_o, 2'b00);
    mem_done_i = 1; mem_rdata_i = 32'h80; tick();
    chk("lb_en", cdb_LS_en_o, 1);
    chk("lb_data", cdb_LS_data_o, 32'hFFFFFF80);
    chk("lb_tag", cdb_LS_tag_o, 5);
    push(4'b0100, 32'h100, 32'h0, 4'd6);
    commit_en_i = 1; tick();
    wait_busy("lbu_issue");
    mem_done_i = 1; mem_rdata_i = 32'h80; tick();
    chk("lbu_data", cdb_LS_data_o, 32'h00000080);
    chk("lbu_tag", cdb_LS_tag_o, 6);
    // store waits for credit
    push(4'b1010, 32'h200, 32'hDEADBEEF, 4'd1);
    seen = 0;
    repeat (20) begin tick(); seen |= mem_req_o; end
    chk("sw_wait", seen, 0);
    commit_en_i = 1; tick();
    wait_busy("sw_issue");
    chk("sw_we", mem_we_o, 1);
    chk("sw_size", mem_size_o, 2'b10);
    chk("sw_wdata", mem_wdata_o, 32'hDEADBEEF);
    mem_done_i = 1; tick();
    chk("sw_nocdb", cdb_LS_en_o, 0);
    // fill, overflow, then drain in order
    for (int i = 0; i < 9; i++) begin
      push(4'b0010, 32'(i * 4), 32'h0, 4'(i));
      if (i == 5) chk("full6", full_o, 0);
      if (i == 6) chk("full7", full_o, 1);
    end
    for (int i = 0; i < 40; i++) begin
      commit_en_i = i < 8; mem_done_i = m_busy; mem_rdata_i = $urandom;
      tick();
      if (cdb_LS_en_o) got.push_back(cdb_LS_tag_o);
    end
    chk("drain_n", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("drain_order", got[i], 4'(i));
    chk("drain_full", full_o, 0);
    // clear drops everything but the committed head
    for (int i = 1; i <= 4; i++) push(4'b0010, $urandom, 32'h0, 4'(i));
    commit_en_i = 1; tick();
    clear = 1; tick();
    ncdb = 0; got.delete();
    for (int i = 0; i < 12; i++) begin
      mem_done_i = m_busy; mem_rdata_i = $urandom; tick();
      if (cdb_LS_en_o) begin ncdb++; got.push_back(cdb_LS_tag_o); end
    end
    chk("clr_ncdb", ncdb, 1);
    if (got.size() > 0) chk("clr_tag", got[0], 1);
    // clear while a load is in flight
    push(4'b0010, 32'h300, 32'h0, 4'd9);
    commit_en_i = 1; tick();
    wait_busy("kill_issue");
    clear = 1; tick();
    mem_done_i = 1; tick();
    chk("kill_cdb", cdb_LS_en_o, 0);
    chk("kill_req", mem_req_o, 0);
    // reset during a stalled transaction
    rst = 1; tick();
    push(4'b0010, 32'h400, 32'h0, 4'd3);
    commit_en_i = 1; tick();
    wait_busy("rst_issue");
    repeat (5) tick();
`ifdef LSB_STALL_CNT_EN
    chk("stall5", stall_cnt_o, 5);
`endif
    rst = 1; tick();
    chk("rstb_req", mem_req_o, 0);
    chk("rstb_we", mem_we_o, 0);
    chk("rstb_addr", mem_addr_o, 0);
    chk("rstb_full", full_o, 0);
`ifdef LSB_STALL_CNT_EN
    chk("stall0", stall_cnt_o, 0);
`endif
    tick();
    chk("rstb_idle", mem_req_o, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rdy = $urandom_range(0, 9) != 0;
      push_i = 1'($urandom_range(0, 1));
      op_i = rand_op();
      addr_i = $urandom; data_i = $urandom; tag_i = TAG_W'($urandom);
      commit_en_i = $urandom_range(0, 2) == 0;
      clear = $urandom_range(0, 39) == 0;
      mem_done_i = $urandom_range(0, 2) == 0;
      mem_rdata_i = $urandom;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
